// File: rtl/fifo_rd_prefetch.sv
// Prefetch buffer in front of a 1-cycle-latency SRAM FIFO: read issued in cycle t lands at m_data_o in t+2.
// Backpressure: m_ready_i low holds the head; reads stop once buffered + in-flight words reach BUF_DEPTH.
module fifo_rd_prefetch #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable_i,
  input  logic                           flush_i,
  input  logic                           fifo_empty_i,
  output logic                           fifo_rden_o,
  input  logic [DATA_WIDTH-1:0]          fifo_rdata_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [DATA_WIDTH-1:0]          m_data_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy_o
);

  localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] LAST    = PW'(BUF_DEPTH - 1);
  localparam logic [OW:0]   DEPTH_W = (OW + 1)'(BUF_DEPTH);
  localparam logic [OW-1:0] FULL    = OW'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [OW-1:0]         occ;
  logic                  inflight;
  logic                  running;
  logic                  pop;
  logic                  cap;
  logic [OW:0]           committed;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign m_valid_o   = (occ != '0);
  assign pop         = m_valid_o && m_ready_i;
  assign cap         = inflight && !flush_i;
  assign occupancy_o = occ;
  assign m_data_o    = m_valid_o ? mem[head] : '0;

  // Slots already spoken for: held words that survive this edge plus the word still on its way.
  assign committed   = {1'b0, occ} - {{OW{1'b0}}, pop} + {{OW{1'b0}}, inflight};

  // running keeps reads off until the first edge after reset is released.
  assign fifo_rden_o = running && enable_i && !fifo_empty_i && !flush_i && (committed < DEPTH_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      inflight <= 1'b0;
      running  <= 1'b0;
    end else begin
      running <= 1'b1;
      if (flush_i) begin
        head     <= '0;
        tail     <= '0;
        occ      <= '0;
        inflight <= 1'b0;
      end else begin
        inflight <= fifo_rden_o;
        if (pop) head <= ptr_next(head);
        if (cap) tail <= ptr_next(tail);
        occ <= occ + OW'(cap) - OW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap) mem[tail] <= fifo_rdata_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(cap && occ == FULL));

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Directed bench for fifo_rd_prefetch with a queue-based model of the buffer and upstream FIFO.
module tb_fifo_rd_prefetch;
  localparam int DW = 32;
  localparam int D  = 2;
  localparam int OW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable_i;
  logic          flush_i;
  logic          fifo_empty_i;
  logic          fifo_rden_o;
  logic [DW-1:0] fifo_rdata_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_data_o;
  logic [OW-1:0] occupancy_o;

  fifo_rd_prefetch #(.DATA_WIDTH(DW), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .flush_i(flush_i),
    .fifo_empty_i(fifo_empty_i), .fifo_rden_o(fifo_rden_o), .fifo_rdata_i(fifo_rdata_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int nfail = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] mbuf[$];
  logic          pend;
  logic [DW-1:0] pend_w;
  logic          hold;

  int            cyc_n;
  int            rden_cyc[$];
  int            out_cyc[$];
  logic [DW-1:0] out_dat[$];

  logic          s_rden;
  logic          s_valid;
  logic [OW-1:0] s_occ;
  logic [DW-1:0] s_data;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    q.push_back(w);
    fifo_empty_i = 1'b0;
  endtask

  task automatic clear_log();
    rden_cyc.delete();
    out_cyc.delete();
    out_dat.delete();
  endtask

  // One clock cycle: check outputs against the model at negedge, advance model at posedge.
  task automatic cyc();
    logic pop_e;
    logic rden_e;
    int   sum;
    @(negedge clk);
    cyc_n++;
    s_rden  = fifo_rden_o;
    s_valid = m_valid_o;
    s_occ   = occupancy_o;
    s_data  = m_data_o;
    pop_e   = (mbuf.size() > 0) && m_ready_i;
    sum     = mbuf.size() - (pop_e ? 1 : 0) + (pend ? 1 : 0);
    rden_e  = !hold && enable_i && !fifo_empty_i && !flush_i && (sum < D);
    chk("rden", DW'(s_rden), DW'(rden_e));
    chk("valid", DW'(s_valid), DW'(mbuf.size() > 0));
    chk("occupancy", DW'(s_occ), DW'(mbuf.size()));
    if (mbuf.size() > 0) chk("data", s_data, mbuf[0]);
    if (s_rden) rden_cyc.push_back(cyc_n);
    if (pop_e) begin
      out_cyc.push_back(cyc_n);
      out_dat.push_back(s_data);
    end
    @(posedge clk);
    if (flush_i) begin
      mbuf.delete();
      pend = 1'b0;
    end else begin
      if (pop_e) void'(mbuf.pop_front());
      if (pend) mbuf.push_back(pend_w);
      pend = s_rden;
    end
    if (s_rden) pend_w = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
    hold = 1'b0;
    #1;
    fifo_rdata_i = pend_w;
    fifo_empty_i = (q.size() == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_push;
    int errs;
    int lim;
    rst_n = 1'b0; enable_i = 1'b1; flush_i = 1'b0; fifo_empty_i = 1'b1;
    m_ready_i = 1'b1; fifo_rdata_i = '0;
    pend = 1'b0; pend_w = '0; hold = 1'b1; cyc_n = 0;

    @(posedge clk); #1;
    chk("reset_occ", DW'(occupancy_o), 0);
    chk("reset_valid", DW'(m_valid_o), 0);
    chk("reset_rden", DW'(fifo_rden_o), 0);
    chk("reset_data", m_data_o, 0);
    for (int i = 0; i < 4; i++) push(32'hA0 + i);
    rst_n = 1'b1; hold = 1'b1;

    // Preloaded FIFO streams at full rate.
    run(10);
    chk("p030_rden_count", rden_cyc.size(), 4);
    chk("p030_out_count", out_dat.size(), 4);
    if (rden_cyc.size() == 4 && out_dat.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("p030_rden_cycle", rden_cyc[i], rden_cyc[0] + i);
        chk("p030_out_cycle", out_cyc[i], rden_cyc[0] + 2 + i);
        chk("p030_out_data", out_dat[i], 32'hA0 + i);
      end

    // Stalled consumer: buffer fills to depth, then drains gap-free.
    clear_log();
    m_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) push(32'hB0 + i);
    run(6);
    chk("p031_rden_count", rden_cyc.size(), 2);
    chk("p031_occ", DW'(s_occ), 2);
    chk("p031_head", s_data, 32'hB0);
    clear_log();
    m_ready_i = 1'b1;
    run(14);
    chk("p031_out_count", out_dat.size(), 8);
    if (out_dat.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk("p031_out_data", out_dat[i], 32'hB0 + i);
        chk("p031_out_cycle", out_cyc[i], out_cyc[0] + i);
      end

    // Empty FIFO, then a single word.
    clear_log();
    run(4);
    chk("p032_idle_rden", rden_cyc.size(), 0);
    push(32'h55);
    run(5);
    chk("p032_rden_count", rden_cyc.size(), 1);
    chk("p032_out_count", out_dat.size(), 1);
    if (out_dat.size() == 1 && rden_cyc.size() == 1) begin
      chk("p032_out_data", out_dat[0], 32'h55);
      chk("p032_latency", out_cyc[0], rden_cyc[0] + 2);
    end

    // Flush with one word held and one in flight.
    clear_log();
    m_ready_i = 1'b0;
    push(32'hC0); push(32'hC1);
    run(2);
    flush_i = 1'b1;
    cyc();
    chk("p033_occ_before", DW'(s_occ), 1);
    chk("p033_rden_count", rden_cyc.size(), 2);
    flush_i = 1'b0;
    cyc();
    chk("p033_occ_after", DW'(s_occ), 0);
    chk("p033_valid_after", DW'(s_valid), 0);
    m_ready_i = 1'b1;
    push(32'hD0);
    run(5);
    chk("p033_out_count", out_dat.size(), 1);
    if (out_dat.size() == 1) chk("p033_out_data", out_dat[0], 32'hD0);

    // Asynchronous reset mid-stream.
    clear_log();
    for (int i = 0; i < 6; i++) push(32'hE0 + i);
    run(3);
    #2 rst_n = 1'b0;
    #1;
    chk("p034_valid", DW'(m_valid_o), 0);
    chk("p034_rden", DW'(fifo_rden_o), 0);
    chk("p034_occ", DW'(occupancy_o), 0);
    mbuf.delete(); pend = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; hold = 1'b1;
    clear_log();
    run(12);
    chk("p034_out_count", out_dat.size(), 3);
    if (out_dat.size() == 3)
      for (int i = 0; i < 3; i++) chk("p034_out_data", out_dat[i], 32'hE3 + i);

    // Random backpressure and enable over 1000 words.
    clear_log();
    n_push = 0;
    lim = 0;
    while (out_dat.size() < 1000 && lim < 20000) begin
      if (n_push < 1000 && ($urandom % 2) == 0) begin
        push(32'h1000 + n_push);
        n_push++;
      end
      m_ready_i = $urandom_range(0, 1) == 1;
      enable_i  = ($urandom % 4) != 0;
      cyc();
      lim++;
    end
    chk("p035_out_count", out_dat.size(), 1000);
    errs = 0;
    for (int i = 0; i < out_dat.size() && i < 1000; i++)
      if (out_dat[i] !== 32'h1000 + i) errs++;
    chk("p035_order_errors", errs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
